// File: rtl/aes_round_controller.sv
// -----------------------------------------------------------------------------
// aes_round_controller
//
// Sequences one AES block operation over the round datapath. After a start
// request it waits for the key schedule, then steps the datapath through the
// initial AddRoundKey, the Nr-1 middle rounds and the final round. Each cycle
// it presents the matching 128-bit round key. Encrypt uses keys 0..Nr in
// order. Decrypt uses keys Nr..0.
//
// Parameters:
//   Nr  number of rounds (10/12/14 for AES-128/192/256)
//   RW  width of round_idx, 2**RW > Nr
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request one block operation (sampled in IDLE only)
//   decrypt      key order for the accepted operation (latched on accept)
//   key_ready    key schedule valid
//   key_sched    expanded key, round key 0 in the most significant 128 bits
//   busy         high in every state except IDLE
//   round_idx    current round number, 0..Nr
//   round_key    key for the current round (0 when no round is active)
//   sel_initial  datapath performs AddRoundKey only
//   sel_middle   datapath performs a full round
//   sel_final    datapath performs the final round (no MixColumns)
//   state_we     datapath captures its result at the next edge
//   done         one-cycle pulse, block result valid
// -----------------------------------------------------------------------------
module aes_round_controller #(
  parameter int Nr = 10,
  parameter int RW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  decrypt,
  input  logic                  key_ready,
  input  logic [(Nr+1)*128-1:0] key_sched,
  output logic                  busy,
  output logic [RW-1:0]         round_idx,
  output logic [127:0]          round_key,
  output logic                  sel_initial,
  output logic                  sel_middle,
  output logic                  sel_final,
  output logic                  state_we,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  // Registered Moore outputs, always loaded with the decode of the state
  // being entered so they line up with the state register.
  typedef struct packed {
    logic busy;
    logic sel_initial;
    logic sel_middle;
    logic sel_final;
    logic state_we;
    logic done;
  } outs_t;

  localparam logic [RW-1:0] IDX_LAST_MID = RW'(Nr - 1);
  localparam logic [RW-1:0] IDX_FINAL    = RW'(Nr);
  localparam logic [RW-1:0] IDX_ONE      = RW'(1);

  state_t      state;
  outs_t       outs;
  logic        mode;      // latched decrypt flag of the running operation
  logic [RW-1:0] key_idx;
  logic [127:0]  keys [0:Nr];

  function automatic outs_t decode(input state_t s);
    outs_t o;
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned; the same habit keeps combinational blocks latch-free.
    o = '0;
    o.busy = (s != IDLE);
    case (s)
      INIT:    o.sel_initial = 1'b1;
      ROUND:   o.sel_middle  = 1'b1;
      FINAL:   o.sel_final   = 1'b1;
      DONE:    o.done        = 1'b1;
      default: ;
    endcase
    o.state_we = o.sel_initial | o.sel_middle | o.sel_final;
    return o;
  endfunction

  // NOTE: state and every registered output use non-blocking assignments so
  // all of them update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      outs      <= '0;
      round_idx <= '0;
      mode      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_KEY;
            outs      <= decode(WAIT_KEY);
            mode      <= decrypt;
            round_idx <= '0;
          end
        end

        WAIT_KEY: begin
          if (key_ready) begin
            state     <= INIT;
            outs      <= decode(INIT);
            round_idx <= '0;
          end
        end

        INIT: begin
          if (!key_ready) begin
            // Schedule went invalid: abandon and wait for it again.
            state     <= WAIT_KEY;
            outs      <= decode(WAIT_KEY);
            round_idx <= '0;
          end else if (Nr == 1) begin
            state     <= FINAL;
            outs      <= decode(FINAL);
            round_idx <= IDX_FINAL;
          end else begin
            state     <= ROUND;
            outs      <= decode(ROUND);
            round_idx <= IDX_ONE;
          end
        end

        ROUND: begin
          if (!key_ready) begin
            state     <= WAIT_KEY;
            outs      <= decode(WAIT_KEY);
            round_idx <= '0;
          end else if (round_idx == IDX_LAST_MID) begin
            state     <= FINAL;
            outs      <= decode(FINAL);
            round_idx <= IDX_FINAL;
          end else begin
            round_idx <= round_idx + IDX_ONE;
          end
        end

        FINAL: begin
          if (!key_ready) begin
            state     <= WAIT_KEY;
            outs      <= decode(WAIT_KEY);
            round_idx <= '0;
          end else begin
            state <= DONE;
            outs  <= decode(DONE);
          end
        end

        DONE: begin
          // A start seen here is dropped; it must be raised again in IDLE.
          state     <= IDLE;
          outs      <= decode(IDLE);
          round_idx <= '0;
        end

        default: begin
          state     <= IDLE;
          outs      <= '0;
          round_idx <= '0;
        end
      endcase
    end
  end

  // Unpack the schedule so round key k sits at keys[k].
  for (genvar k = 0; k <= Nr; k++) begin : g_key
    assign keys[k] = key_sched[(Nr+1)*128-1-128*k -: 128];
  end

  // Decrypt walks the schedule backwards.
  assign key_idx   = mode ? (IDX_FINAL - round_idx) : round_idx;
  assign round_key = outs.state_we ? keys[key_idx] : '0;

  assign busy        = outs.busy;
  assign sel_initial = outs.sel_initial;
  assign sel_middle  = outs.sel_middle;
  assign sel_final   = outs.sel_final;
  assign state_we    = outs.state_we;
  assign done        = outs.done;

endmodule

// File: tb/tb_aes_round_controller.sv
// -----------------------------------------------------------------------------
// tb_aes_round_controller
//
// Drives an Nr=10 and an Nr=14 controller from shared clock, reset, decrypt,
// key_ready and key schedule, with a separate start per instance. Expected
// behaviour comes from a round-by-round model: wait phase, rounds 0..Nr with
// key index r (encrypt) or Nr-r (decrypt), one done cycle, then idle.
// Observed outputs are packed as
// {busy, round_idx, sel_initial, sel_middle, sel_final, state_we, done, key}.
// -----------------------------------------------------------------------------
module tb_aes_round_controller;

  logic          clk;
  logic          reset;
  logic          start10, start14;
  logic          decrypt;
  logic          key_ready;
  logic [1919:0] ks;

  logic          busy10, si10, sm10, sf10, we10, done10;
  logic [3:0]    idx10;
  logic [127:0]  key10;
  logic          busy14, si14, sm14, sf14, we14, done14;
  logic [3:0]    idx14;
  logic [127:0]  key14;

  int total;
  int bad;

  aes_round_controller #(.Nr(10), .RW(4)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .decrypt(decrypt),
    .key_ready(key_ready), .key_sched(ks[1407:0]),
    .busy(busy10), .round_idx(idx10), .round_key(key10),
    .sel_initial(si10), .sel_middle(sm10), .sel_final(sf10),
    .state_we(we10), .done(done10)
  );

  aes_round_controller #(.Nr(14), .RW(4)) dut14 (
    .clk(clk), .reset(reset), .start(start14), .decrypt(decrypt),
    .key_ready(key_ready), .key_sched(ks),
    .busy(busy14), .round_idx(idx14), .round_key(key14),
    .sel_initial(si14), .sel_middle(sm14), .sel_final(sf14),
    .state_we(we14), .done(done14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  localparam logic [137:0] WAIT_VEC = {1'b1, 137'd0};
  localparam logic [137:0] DONE_VEC = {1'b1, 4'd0, 5'b00001, 128'd0};

  function automatic logic [137:0] obs(input int nr);
    if (nr == 14) return {busy14, idx14, si14, sm14, sf14, we14, done14, key14};
    return {busy10, idx10, si10, sm10, sf10, we10, done10, key10};
  endfunction

  // Reference for round r of an operation on an nr-round schedule.
  function automatic logic [137:0] exp_round(input int nr, input int r, input bit dec);
    int k;
    logic [127:0] key;
    k   = dec ? nr - r : r;
    key = ks[(nr+1)*128-1-128*k -: 128];
    return {1'b1, 4'(r), (r == 0), (r > 0 && r < nr), (r == nr), 1'b1, 1'b0, key};
  endfunction

  task automatic set_start(input int nr, input logic v);
    if (nr == 14) start14 = v;
    else start10 = v;
  endtask

  task automatic rand_ks;
    for (int i = 0; i < 60; i++) ks[32*i +: 32] = $urandom;
  endtask

  // Runs one operation from a negedge in IDLE and checks every cycle.
  // extra: cycles key_ready is held low after acceptance.
  // drop_at: round at which key_ready drops once (-1 = never).
  // poke_at: round at which start is pulsed while busy (-1 = never).
  task automatic run_op(input int nr, input bit dec, input int extra,
                        input int drop_at, input int poke_at, input string name);
    int n;
    int r;
    bit dropped;
    logic [137:0] o, e;
    n = 0;
    dropped = 1'b0;
    key_ready = (extra == 0);
    decrypt = dec;
    set_start(nr, 1'b1);
    @(negedge clk); n++;
    set_start(nr, 1'b0);
    decrypt = ~dec;  // must not affect the running operation
    for (int i = 0; i <= extra; i++) begin
      o = obs(nr);
      total++;
      if (o !== WAIT_VEC) begin
        bad++;
        $display("FAIL %s wait cyc=%0d got=%h exp=%h", name, n, o, WAIT_VEC);
      end
      if (i == extra) key_ready = 1'b1;
      @(negedge clk); n++;
    end
    r = 0;
    while (r <= nr) begin
      o = obs(nr);
      e = exp_round(nr, r, dec);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s round=%0d got=%h exp=%h", name, r, o, e);
      end
      set_start(nr, r == poke_at);
      if (r == drop_at && !dropped) begin
        dropped = 1'b1;
        key_ready = 1'b0;
        @(negedge clk); n++;
        set_start(nr, 1'b0);
        o = obs(nr);
        total++;
        if (o !== WAIT_VEC) begin
          bad++;
          $display("FAIL %s drop_wait got=%h exp=%h", name, o, WAIT_VEC);
        end
        key_ready = 1'b1;
        r = 0;
      end else begin
        r++;
      end
      @(negedge clk); n++;
    end
    set_start(nr, 1'b0);
    o = obs(nr);
    o[136:133] = '0;  // round_idx in the done cycle is not checked
    total++;
    if (o !== DONE_VEC) begin
      bad++;
      $display("FAIL %s done got=%h exp=%h", name, o, DONE_VEC);
    end
    if (drop_at < 0) begin
      total++;
      if (n - 1 != nr + 2 + extra) begin
        bad++;
        $display("FAIL %s latency got=%0d exp=%0d", name, n - 1, nr + 2 + extra);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = obs(nr);
      total++;
      if (o !== '0) begin
        bad++;
        $display("FAIL %s idle%0d got=%h exp=0", name, i, o);
      end
    end
  endtask

  task automatic test_reset;
    logic [137:0] o;
    reset = 1'b0; start10 = 1'b0; start14 = 1'b0;
    decrypt = 1'b0; key_ready = 1'b0; ks = '0;
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      o = obs(i == 0 ? 10 : 14);
      total++;
      if (o !== '0) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h exp=0", i, o);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    o = obs(10);
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=0", o);
    end
  endtask

  task automatic test_encrypt;
    rand_ks();
    run_op(10, 1'b0, 0, -1, -1, "encrypt");
    rand_ks();
    run_op(10, 1'b1, 0, -1, -1, "decrypt_rand");
  endtask

  task automatic test_fips_decrypt;
    ks = '0;
    ks[1407:0] = {
      128'h000102030405060708090a0b0c0d0e0f,
      128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
      128'hb692cf0b643dbdf1be9bc5006830b3fe,
      128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
      128'h47f7f7bc95353e03f96c32bcfd058dfd,
      128'h3caaa3e8a99f9deb50f3af57adf622aa,
      128'h5e390f7df7a69296a7553dc10aa31f6b,
      128'h14f9701ae35fe28c440adf4d4ea9c026,
      128'h47438735a41c65b9e016baf4aeb6ba68,
      128'h549932d1f08557681093ed9cbe2c974e,
      128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    run_op(10, 1'b1, 0, -1, -1, "fips_decrypt");
    run_op(10, 1'b0, 0, -1, -1, "fips_encrypt");
  endtask

  task automatic test_wait_key;
    rand_ks();
    run_op(10, 1'($urandom), 5, -1, -1, "wait_key");
  endtask

  task automatic test_key_drop;
    rand_ks();
    run_op(10, 1'($urandom), 0, 4, -1, "key_drop");
  endtask

  task automatic test_start_ignored;
    rand_ks();
    run_op(10, 1'($urandom), 0, -1, 3, "start_busy");
  endtask

  task automatic test_back_to_back;
    int dones;
    int p;
    int per;
    bit dec;
    logic [137:0] o, e;
    per = 14;  // wait, 11 rounds, done, idle
    dec = 1'($urandom);
    rand_ks();
    key_ready = 1'b1;
    decrypt = dec;
    start10 = 1'b1;
    dones = 0;
    @(negedge clk);
    for (int c = 0; c < 2 * per; c++) begin
      p = c % per;
      o = obs(10);
      if (p == 0) e = WAIT_VEC;
      else if (p <= 11) e = exp_round(10, p - 1, dec);
      else if (p == 12) begin
        e = DONE_VEC;
        o[136:133] = '0;
      end else e = '0;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", c, o, e);
      end
      if (o[128]) dones++;
      if (c == 2 * per - 1) start10 = 1'b0;
      @(negedge clk);
    end
    o = obs(10);
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL b2b_stop got=%h exp=0", o);
    end
    total++;
    if (dones != 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d exp=2", dones);
    end
  endtask

  task automatic test_async_reset;
    bit found;
    logic [137:0] o;
    rand_ks();
    key_ready = 1'b1;
    decrypt = 1'b0;
    start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (idx10 == 4'd6 && sm10) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL areset_reach_round6 got=0 exp=1");
    end
    #2 reset = 1'b1;
    #1;
    o = obs(10);
    total++;
    if (o !== '0) begin
      bad++;
      $display("FAIL areset_outputs got=%h exp=0", o);
    end
    @(negedge clk);
    reset = 1'b0;
    rand_ks();
    run_op(10, 1'($urandom), 0, -1, -1, "after_reset");
  endtask

  task automatic test_nr14;
    rand_ks();
    run_op(14, 1'b0, 0, -1, -1, "nr14_enc");
    rand_ks();
    run_op(14, 1'b1, 0, -1, -1, "nr14_dec");
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_encrypt();
    test_fips_decrypt();
    test_wait_key();
    test_key_drop();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_nr14();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
